// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receiver link.
package rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_assembler.sv
// Shift-register datapath: latches the frame bit order and builds the word one bit per clock.
module bit_assembler
    import rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             serial_in,
    output logic [WIDTH-1:0] shreg_next
);

    logic             dir_r;
    logic             dir_eff_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_next_s;

    // Bit 0 must use the incoming dir, since the latch only updates on that same edge.
    always_comb begin
        dir_eff_s    = dir_r;
        shreg_next_s = shreg_r;
        if (load) begin
            dir_eff_s = dir;
        end else begin
            dir_eff_s = dir_r;
        end
        if (dir_eff_s == DIR_MSB_FIRST) begin
            shreg_next_s = {shreg_r[WIDTH-2:0], serial_in};
        end else begin
            shreg_next_s = {serial_in, shreg_r[WIDTH-1:1]};
        end
    end

    // Bit-order latch and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_r   <= DIR_LSB_FIRST;
            shreg_r <= '0;
        end else begin
            if (load) begin
                dir_r <= dir;
            end
            if (load || shift_en) begin
                shreg_r <= shreg_next_s;
            end
        end
    end

    assign shreg_next = shreg_next_s;

endmodule

// File: rtl/serial_receiver.sv
// Serial-to-parallel receiver: frame FSM, bit counter, double-buffered valid/ready output
// and sticky overrun flag.
module serial_receiver
    import rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serialIn,
    input  logic             start,
    input  logic             dir,
    input  logic             outReady,
    input  logic             clrOverrun,
    output logic [WIDTH-1:0] parallelOut,
    output logic             outValid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    logic             load_s;
    logic             shift_s;
    logic             complete_s;
    logic             xfer_s;
    logic [WIDTH-1:0] shreg_next_s;
    logic [WIDTH-1:0] hold_r;
    logic             valid_r;
    logic             busy_r;
    logic             overrun_r;

    bit_assembler #(.WIDTH(WIDTH)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .shift_en   (shift_s),
        .dir        (dir),
        .serial_in  (serialIn),
        .shreg_next (shreg_next_s)
    );

    // Frame FSM next-state and counter logic; start is only honoured in IDLE.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    cnt_next_s   = CNT_ONE;
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    complete_s   = 1'b1;
                    cnt_next_s   = '0;
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s = cnt_r + CW'(1);
                end
            end
            default: begin
                cnt_next_s   = '0;
                state_next_s = IDLE;
            end
        endcase
    end

    assign xfer_s = valid_r && outReady;

    // FSM state, counter and registered busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s == SHIFT);
        end
    end

    // Holding register and handshake; a completed word is dropped only when the slot stays full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (complete_s && (!valid_r || xfer_s)) begin
                hold_r  <= shreg_next_s;
                valid_r <= 1'b1;
            end else if (xfer_s) begin
                valid_r <= 1'b0;
            end
            if (complete_s && valid_r && !outReady) begin
                overrun_r <= 1'b1;
            end else if (clrOverrun) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign parallelOut = hold_r;
    assign outValid    = valid_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;

endmodule
